// File: rtl/cam_capture_pkg.sv
// Shared types and helpers for the OV7670 camera-to-framebuffer capture path.
package cam_capture_pkg;

  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    WAIT_VSYNC,
    CAPTURE
  } state_t;

  // RGB565 byte pair (high byte first) reduced to RGB332: R[4:2], G[5:3], B[4:3].
  function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

endpackage

// File: rtl/cam_frame_capture_if.sv
// Camera pin bundle plus framebuffer write port; master = capture block, slave = environment.
interface cam_frame_capture_if #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 8
);
  logic              cam_pclk;
  logic              cam_href;
  logic              cam_vsync;
  logic [7:0]        cam_data;
  logic              we;
  logic [ADDR_W-1:0] write_addr;
  logic [PIX_W-1:0]  wr_data;

  modport master (
    input  cam_pclk, cam_href, cam_vsync, cam_data,
    output we, write_addr, wr_data
  );

  modport slave (
    output cam_pclk, cam_href, cam_vsync, cam_data,
    input  we, write_addr, wr_data
  );
endinterface

// File: rtl/cam_sync_edge.sv
// Multi-flop synchroniser for one asynchronous camera strobe, with rise/fall pulses (STAGES >= 2).
module cam_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/cam_frame_capture.sv
// OV7670 parallel-bus capture into the framebuffer write port, with clear sweep and snapshot mode.
// Optional build macro CAM_TEST_PATTERN_EN replaces pixel data by 8 vertical colour bars.
module cam_frame_capture
  import cam_capture_pkg::*;
#(
  parameter int H_RES         = DEF_H_RES,
  parameter int V_RES         = DEF_V_RES,
  parameter int ADDR_W        = 19,
  parameter int BYTES_PER_PIX = 2,
  parameter int PIX_W         = 8,
  parameter int CLEAR_VALUE   = 244,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  cam_frame_capture_if.master bus,
  input  logic                snapshot,
  input  logic                arm,
  input  logic                clear_req,
  output logic                busy,
  output logic                frame_done,
  output logic [7:0]          frame_count,
  output logic                line_err
);

  localparam int XW = $clog2(H_RES + 1);
  localparam int YW = $clog2(V_RES + 1);
  localparam logic [XW-1:0]     X_MAX     = XW'(H_RES);
  localparam logic [YW-1:0]     Y_MAX     = YW'(V_RES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_RES);

  logic pclk_lvl, pclk_rise, pclk_fall;
  logic href_lvl, href_rise, href_fall;
  logic vs_lvl, vs_rise, vs_fall;
  logic unused_sync;

  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pclk (
    .clk_i(CLOCK_50), .rst_ni(reset_n), .d_i(bus.cam_pclk),
    .q_o(pclk_lvl), .rise_o(pclk_rise), .fall_o(pclk_fall)
  );

  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_href (
    .clk_i(CLOCK_50), .rst_ni(reset_n), .d_i(bus.cam_href),
    .q_o(href_lvl), .rise_o(href_rise), .fall_o(href_fall)
  );

  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vsync (
    .clk_i(CLOCK_50), .rst_ni(reset_n), .d_i(bus.cam_vsync),
    .q_o(vs_lvl), .rise_o(vs_rise), .fall_o(vs_fall)
  );

  assign unused_sync = pclk_lvl ^ pclk_fall ^ vs_lvl;

  // Data byte delayed by the synchroniser depth so it lines up with the pclk rise pulse.
  logic [7:0] data_pipe_q [SYNC_STAGES];
  logic [7:0] byte_s;

  always_ff @(posedge CLOCK_50) begin
    data_pipe_q[0] <= bus.cam_data;
    for (int i = 1; i < SYNC_STAGES; i++) data_pipe_q[i] <= data_pipe_q[i-1];
  end

  assign byte_s = data_pipe_q[SYNC_STAGES-1];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d, clr_idx;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic              phase_q, phase_d;
  logic              line_err_q, line_err_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  data_q, data_d;
  logic [7:0]        hi_q;
  logic              hi_load, pix_done, clr_wr, byte_take;
  logic [PIX_W-1:0]  pix_val;

  assign byte_take = pclk_rise & href_lvl;

`ifdef CAM_TEST_PATTERN_EN
  logic [XW+2:0] x_scaled;
  logic [2:0]    bar;
  logic [23:0]   bar_rep;

  always_comb begin
    x_scaled = {x_q, 3'b000};
    bar      = 3'(x_scaled / (XW+3)'(H_RES));
    bar_rep  = {8{bar}};
    if (BYTES_PER_PIX == 2) pix_val = PIX_W'({bar, bar, bar[1:0]});
    else                    pix_val = bar_rep[23 -: PIX_W];
  end
`else
  always_comb begin
    if (BYTES_PER_PIX == 2) pix_val = PIX_W'(rgb565_to_rgb332(hi_q, byte_s));
    else                    pix_val = PIX_W'(byte_s);
  end
`endif

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    line_base_d  = line_base_q;
    phase_d      = phase_q;
    line_err_d   = line_err_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    we_d         = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    hi_load      = 1'b0;
    pix_done     = 1'b0;
    // clear_req behaves as CLEAR at index 0, overriding whatever the current state wanted.
    clr_wr       = clear_req | (state_q == CLEAR);
    clr_idx      = clear_req ? '0 : clr_cnt_q;

    if (clr_wr) begin
      we_d   = 1'b1;
      addr_d = clr_idx;
      data_d = PIX_W'(CLEAR_VALUE);
      if (clear_req) line_err_d = 1'b0;
      if (clr_idx == LAST_ADDR) begin
        clr_cnt_d = '0;
        if (snapshot) state_d = IDLE;
        else          state_d = WAIT_VSYNC;
      end else begin
        clr_cnt_d = clr_idx + ADDR_W'(1);
        state_d   = CLEAR;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) state_d = WAIT_VSYNC;
        end
        WAIT_VSYNC: begin
          if (vs_fall) begin
            x_d         = '0;
            y_d         = '0;
            line_base_d = '0;
            phase_d     = 1'b0;
            state_d     = CAPTURE;
          end
        end
        CAPTURE: begin
          if (vs_rise) begin
            if (y_q == Y_MAX) begin
              frame_done_d = 1'b1;
              frame_cnt_d  = frame_cnt_q + 8'd1;
              if (snapshot) state_d = IDLE;
              else          state_d = WAIT_VSYNC;
            end else begin
              state_d = WAIT_VSYNC;
            end
          end else begin
            if (href_rise) phase_d = 1'b0;
            if (byte_take) begin
              if (BYTES_PER_PIX == 2 && !phase_q) begin
                hi_load = 1'b1;
                phase_d = 1'b1;
              end else begin
                phase_d  = 1'b0;
                pix_done = 1'b1;
              end
            end
            // x saturates at H_RES so overlong lines stop writing instead of wrapping.
            if (pix_done && x_q < X_MAX) begin
              x_d = x_q + XW'(1);
              if (y_q < Y_MAX) begin
                we_d   = 1'b1;
                addr_d = line_base_q + ADDR_W'(x_q);
                data_d = pix_val;
              end
            end
            if (href_fall) begin
              if (x_q != '0) begin
                if (y_q < Y_MAX) begin
                  y_d         = y_q + YW'(1);
                  line_base_d = line_base_q + LINE_STEP;
                end
                if (x_q < X_MAX) line_err_d = 1'b1;
              end
              x_d = '0;
            end
          end
        end
        default: state_d = CLEAR;
      endcase
    end

    busy_d = clr_wr | (state_d == CLEAR) | (state_d == CAPTURE);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= CLEAR;
      clr_cnt_q    <= '0;
      x_q          <= '0;
      y_q          <= '0;
      line_base_q  <= '0;
      phase_q      <= 1'b0;
      line_err_q   <= 1'b0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      line_base_q  <= line_base_d;
      phase_q      <= phase_d;
      line_err_q   <= line_err_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (hi_load) hi_q <= byte_s;
  end

  assign bus.we         = we_q;
  assign bus.write_addr = addr_q;
  assign bus.wr_data    = data_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;
  assign frame_count    = frame_cnt_q;
  assign line_err       = line_err_q;

endmodule

// File: tb/tb_cam_frame_capture.sv
// Scoreboard bench for cam_frame_capture on a reduced 16x8 frame with a behavioural camera.
module tb_cam_frame_capture;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int N  = H * V;
  localparam int AW = 8;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic snapshot = 1'b0;
  logic arm = 1'b0;
  logic clear_req = 1'b0;
  logic busy, frame_done, line_err;
  logic [7:0] frame_count;

  cam_frame_capture_if #(.ADDR_W(AW), .PIX_W(PW)) bus();

  cam_frame_capture #(
    .H_RES(H), .V_RES(V), .ADDR_W(AW), .BYTES_PER_PIX(2),
    .PIX_W(PW), .CLEAR_VALUE(244), .SYNC_STAGES(2)
  ) dut (
    .CLOCK_50(clk), .reset_n(rst_n), .bus(bus),
    .snapshot(snapshot), .arm(arm), .clear_req(clear_req),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count), .line_err(line_err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  int          wr_cnt = 0;
  int          fd_cnt = 0;
  logic [31:0] last_addr = 0;
  bit          exp_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_pix(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n) begin
      if (frame_done) fd_cnt++;
      if (bus.we) begin
        wr_cnt++;
        last_addr = 32'(bus.write_addr);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_wr", 32'(bus.write_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq("wr_addr", 32'(bus.write_addr), 32'(e[15:8]));
          check_eq("wr_data", 32'(bus.wr_data), 32'(e[7:0]));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_clear();
    for (int i = 0; i < N; i++) exp_q.push_back({8'(i), 8'd244});
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  task automatic clear_seq();
    int k;
    k = 0;
    while (!bus.we && k < 4) begin
      tick(1);
      k++;
    end
    check_eq("clr_start", 32'(bus.we), 1);
    for (int i = 0; i < N; i++) begin
      check_eq("clr_we", 32'(bus.we), 1);
      check_eq("clr_busy_hi", 32'(busy), 1);
      tick(1);
    end
    check_eq("clr_end_we", 32'(bus.we), 0);
    check_eq("clr_busy_lo", 32'(busy), 0);
    check_eq("clr_sb_empty", exp_q.size(), 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.cam_pclk = 1'b0;
    bus.cam_data = b;
    tick(2);
    bus.cam_pclk = 1'b1;
    tick(2);
  endtask

  task automatic send_line(input int line, input int len, input bit cap, input bit fixed, input int seed);
    bus.cam_href = 1'b1;
    tick(2);
    for (int x = 0; x < len; x++) begin
      logic [7:0] hi, lo;
      hi = fixed ? 8'hF8 : 8'(x * 29 + line * 11 + seed);
      lo = fixed ? 8'h1F : 8'(x * 7 + line * 53 + seed * 3);
      if (cap && x < H && line < V)
        exp_q.push_back({8'(line * H + x), fixed ? 8'hE3 : exp_pix(hi, lo)});
      send_byte(hi);
      send_byte(lo);
    end
    bus.cam_pclk = 1'b0;
    tick(2);
    bus.cam_href = 1'b0;
    tick(4);
    if (cap && len > 0 && len < H) exp_err = 1'b1;
  endtask

  task automatic send_frame(input int nlines, input int len_a, input int b_line, input int len_b,
                            input bit cap, input bit fixed, input int seed);
    bus.cam_vsync = 1'b0;
    tick(4);
    for (int y = 0; y < nlines; y++) send_line(y, (y == b_line) ? len_b : len_a, cap, fixed, seed);
    bus.cam_vsync = 1'b1;
    tick(8);
  endtask

  initial begin
    int fd0, wr0, k;
    bus.cam_pclk  = 1'b0;
    bus.cam_href  = 1'b0;
    bus.cam_vsync = 1'b1;
    bus.cam_data  = 8'h00;
    tick(3);

    // reset state
    check_eq("rst_we", 32'(bus.we), 0);
    check_eq("rst_addr", 32'(bus.write_addr), 0);
    check_eq("rst_data", 32'(bus.wr_data), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_fdone", 32'(frame_done), 0);
    check_eq("rst_fcount", 32'(frame_count), 0);
    check_eq("rst_lerr", 32'(line_err), 0);

    push_clear();
    rst_n = 1'b1;
    clear_seq();

    // continuous capture, fixed RGB565 pair then varying pixels
    fd0 = fd_cnt;
    send_frame(V, H, -1, 0, 1'b1, 1'b1, 0);
    check_eq("f1_done", fd_cnt - fd0, 1);
    check_eq("f1_count", 32'(frame_count), 1);
    check_eq("f1_last_addr", last_addr, N - 1);
    check_eq("f1_sb_empty", exp_q.size(), 0);
    check_eq("f1_busy", 32'(busy), 0);
    send_frame(V, H, -1, 0, 1'b1, 1'b0, 5);
    check_eq("f2_count", 32'(frame_count), 2);
    check_eq("f2_sb_empty", exp_q.size(), 0);

    // snapshot mode
    snapshot = 1'b1;
    send_frame(V, H, -1, 0, 1'b1, 1'b0, 9);
    check_eq("s1_count", 32'(frame_count), 3);
    check_eq("s1_busy_idle", 32'(busy), 0);
    wr0 = wr_cnt;
    fd0 = fd_cnt;
    send_frame(V, H, -1, 0, 1'b0, 1'b0, 13);
    check_eq("s_idle_writes", wr_cnt - wr0, 0);
    check_eq("s_idle_done", fd_cnt - fd0, 0);
    fd0 = fd_cnt;
    pulse_arm();
    send_frame(V, H, -1, 0, 1'b1, 1'b0, 17);
    wr0 = wr_cnt;
    send_frame(V, H, -1, 0, 1'b0, 1'b0, 19);
    check_eq("s_arm_done", fd_cnt - fd0, 1);
    check_eq("s_arm_count", 32'(frame_count), 4);
    check_eq("s_frame2_writes", wr_cnt - wr0, 0);
    pulse_arm();
    send_frame(V, H, -1, 0, 1'b1, 1'b0, 23);
    check_eq("s_rearm_count", 32'(frame_count), 5);
    check_eq("s_sb_empty", exp_q.size(), 0);

    // overlong and short lines
    check_eq("lerr_clean", 32'(line_err), 0);
    snapshot = 1'b0;
    pulse_arm();
    send_frame(V, H, 2, H + 4, 1'b1, 1'b0, 21);
    check_eq("long_count", 32'(frame_count), 6);
    check_eq("long_lerr", 32'(line_err), 0);
    check_eq("long_sb_empty", exp_q.size(), 0);
    send_frame(V, H, 3, H - 4, 1'b1, 1'b0, 33);
    check_eq("short_lerr", 32'(line_err), 32'(exp_err));
    check_eq("short_count", 32'(frame_count), 7);
    send_frame(V, H, -1, 0, 1'b1, 1'b0, 41);
    check_eq("lerr_sticky", 32'(line_err), 32'(exp_err));
    check_eq("sticky_count", 32'(frame_count), 8);

    // aborted frame followed by a full one
    fd0 = fd_cnt;
    send_frame(3, H, -1, 0, 1'b1, 1'b0, 45);
    check_eq("abort_done", fd_cnt - fd0, 0);
    check_eq("abort_count", 32'(frame_count), 8);
    send_frame(V, H, -1, 0, 1'b1, 1'b0, 47);
    check_eq("after_abort_count", 32'(frame_count), 9);
    check_eq("after_abort_sb", exp_q.size(), 0);

    // clear_req mid-capture
    bus.cam_vsync = 1'b0;
    tick(4);
    for (int y = 0; y < 4; y++) send_line(y, H, 1'b1, 1'b0, 51);
    check_eq("pre_clr_sb", exp_q.size(), 0);
    push_clear();
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    check_eq("creq_we", 32'(bus.we), 1);
    check_eq("creq_addr", 32'(bus.write_addr), 0);
    check_eq("creq_data", 32'(bus.wr_data), 244);
    bus.cam_vsync = 1'b1;
    k = 0;
    while (busy && k < 2 * N) begin
      tick(1);
      k++;
    end
    check_eq("creq_busy_lo", 32'(busy), 0);
    check_eq("creq_sb_empty", exp_q.size(), 0);
    check_eq("creq_lerr", 32'(line_err), 0);
    exp_err = 1'b0;
    send_frame(V, H, -1, 0, 1'b1, 1'b0, 55);
    check_eq("post_creq_count", 32'(frame_count), 10);

    // reset asserted mid-CLEAR
    push_clear();
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    tick(20);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_we", 32'(bus.we), 0);
    check_eq("mid_rst_addr", 32'(bus.write_addr), 0);
    check_eq("mid_rst_data", 32'(bus.wr_data), 0);
    check_eq("mid_rst_busy", 32'(busy), 0);
    check_eq("mid_rst_count", 32'(frame_count), 0);
    exp_q.delete();
    tick(3);
    push_clear();
    rst_n = 1'b1;
    clear_seq();
    send_frame(V, H, -1, 0, 1'b1, 1'b0, 61);
    check_eq("final_count", 32'(frame_count), 1);
    check_eq("final_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
